decode_execute_core: RTL and testbench
======================================

# decode_execute_core

Combinational RV32I decode, immediate-generation and ALU stage of the single-cycle CPU. It decodes the fetched 32-bit instruction into register addresses and datapath mux/memory/branch controls, and produces the sign-extended immediate. It also evaluates the ALU on operands chosen by the surrounding datapath muxes. A one-flop synchronous run flag suppresses all side-effecting controls while the core is held in reset.

## Interface
- No parameters.
- `clk` in 1: sole clock; only the run flag is registered.
- `rstn` in 1: synchronous, active-low reset.
- `instruct` in 32: instruction from instruction memory.
- `alu_rs1` in 32: ALU operand A (rs1 or PC, external mux).
- `alu_rs2` in 32: ALU operand B (rs2, imm or 4, external mux).
- `Wadd`, `Radd1`, `Radd2` out 5: rd = [11:7], rs1 = [19:15], rs2 = [24:20].
- `imm` out 32: immediate selected by `exop`.
- `exop` out 3: immediate format.
- `alu_ctr_o` out 6: ALU operation; also drives the internal ALU.
- `branch_o` out 2: 00 none, 01 taken if `zero`=1, 10 taken if `zero`=0.
- `jump_o` out 1: unconditional jump (JAL/JALR).
- `isWreg` out 1: register-file write enable.
- `isWmem` out 1: data-memory write enable.
- `mrs1andpc_ctr` out 1: ALU A select, 0 rs1, 1 PC.
- `mrs1andpc_ctr2` out 1: next-PC base, 0 PC, 1 rs1 (JALR).
- `mrs2andie_ctr` out 2: ALU B select, 00 rs2, 01 imm, 10 constant 4.
- `mrs2_ctr` out 2: store width, 00 word, 01 half, 10 byte.
- `maluandmem_ctr` out 3: writeback select, 000 ALU, 001 LW, 010 LH, 011 LHU, 100 LB, 101 LBU.
- `res` out 32: ALU result.
- `zero` out 1: `res == 0`.

## Operation
- Run flag: cleared at a `clk` edge with `rstn`=0; set at a `clk` edge with `rstn`=1.
- While the run flag is 0: all decode outputs, `imm` and `exop` are 0. The ALU keeps evaluating.
- exop / imm:
  - 0: I-type, sext [31:20].
  - 1: S-type, sext {[31:25],[11:7]}.
  - 2: B-type, sext {[31],[7],[30:25],[11:8],0}.
  - 3: U-type, {[31:12],12'b0}.
  - 4: J-type, sext {[31],[19:12],[20],[30:21],0}.
  - 5: shamt, zero-extended [24:20].
  - 6 and 7 give imm = 0.
- ALU ops (`alu_ctr_o`):
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - Shifts use B[4:0].
  - Codes 11–63 give res = 0.
- Decode by opcode:
  - R-type: ops from funct3/funct7[5]; B=rs2; isWreg.
  - OP-IMM: B=imm, exop 0. SLLI/SRLI/SRAI use exop 5, with funct7[5] selecting SRA.
  - LUI: exop 3, B=imm, PASSB.
  - AUIPC: A=PC, B=imm, ADD.
  - JAL: jump, A=PC, B=4, ADD, exop 4, ctr2=0.
  - JALR: jump, A=PC, B=4, ADD, exop 0, ctr2=1.
  - Branch, exop 2, B=rs2:
    - BEQ: SUB/01.
    - BNE: SUB/10.
    - BLT: SLT/10.
    - BGE: SLT/01.
    - BLTU: SLTU/10.
    - BGEU: SLTU/01.
  - Load: ADD, B=imm, exop 0, maluandmem_ctr from funct3, isWreg.
  - Store: ADD, B=imm, exop 1, isWmem, mrs2_ctr from funct3.
- `isWreg` is forced 0 when rd = 0.
- Unknown opcode or funct3: every control is 0 (NOP).
- Register addresses come out as raw fields regardless of type.

## Timing
- Decode, imm and ALU are purely combinational; there are no pipeline registers.
- Reset asserted mid-operation: controls go to 0 after the next `clk` edge, not immediately.
- Controls are valid from the first edge with `rstn` high.
- Reset value of every decode output is 0. `res` and `zero` follow `alu_rs1`, `alu_rs2` and `alu_ctr_o` (code 0 = ADD during reset).

## Test plan
- Hold `rstn`=0 for 2 edges with `instruct`=0x00500093 (addi x1,x0,5) -> all controls 0. After the first edge with `rstn`=1 -> isWreg=1, Wadd=1, imm=5, mrs2andie_ctr=01, alu_ctr_o=0.
- `instruct`=0x40208133 (sub x2,x1,x2), alu_rs1=3, alu_rs2=5 -> alu_ctr_o=1, res=0xFFFFFFFE, zero=0.
- `instruct`=0xFE20CEE3 (blt x1,x2,-4), alu_rs1=0xFFFFFFFF, alu_rs2=1 -> SLT, res=1, branch_o=10, imm=0xFFFFFFFC, isWreg=0.
- sw x2,-8(x1) (0xFE20AC23) -> isWmem=1, exop=1, imm=0xFFFFFFF8, mrs2_ctr=00. lbu x3,1(x1) -> maluandmem_ctr=101.
- jalr x1,12(x5) -> jump_o=1, ctr2=1, A=PC, B=4. lui x5,0x12345 -> imm=0x12345000, res=alu_rs2.
- srai, alu_rs1=0x80000000, shamt 4 -> res=0xF8000000. Opcode 0x7F -> all controls 0. addi x0 -> isWreg=0.

Source files
------------

// File: rtl/decode_execute_core.sv
// RV32I decode, immediate generation and ALU for the single-cycle core.
// The only state is a run flag that holds every decode output at zero during reset.
module decode_execute_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] instruct,
    input  logic [31:0] alu_rs1,
    input  logic [31:0] alu_rs2,
    output logic [4:0]  Wadd,
    output logic [4:0]  Radd1,
    output logic [4:0]  Radd2,
    output logic [31:0] imm,
    output logic [2:0]  exop,
    output logic [5:0]  alu_ctr_o,
    output logic [1:0]  branch_o,
    output logic        jump_o,
    output logic        isWreg,
    output logic        isWmem,
    output logic        mrs1andpc_ctr,
    output logic        mrs1andpc_ctr2,
    output logic [1:0]  mrs2andie_ctr,
    output logic [1:0]  mrs2_ctr,
    output logic [2:0]  maluandmem_ctr,
    output logic [31:0] res,
    output logic        zero
);
    localparam logic [6:0] OP_R = 7'h33, OP_I = 7'h13, OP_LUI = 7'h37, OP_AUIPC = 7'h17,
                           OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_BR = 7'h63, OP_LD = 7'h03,
                           OP_ST = 7'h23;
    localparam logic [5:0] ALU_ADD = 6'd0, ALU_SUB = 6'd1, ALU_SLL = 6'd2, ALU_SLT = 6'd3,
                           ALU_SLTU = 6'd4, ALU_XOR = 6'd5, ALU_SRL = 6'd6, ALU_SRA = 6'd7,
                           ALU_OR = 6'd8, ALU_AND = 6'd9, ALU_PASSB = 6'd10;

    logic        r_run;
    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic        w_alt;
    logic [2:0]  w_exop;
    logic [5:0]  w_alu;
    logic [1:0]  w_br, w_bsel, w_m2;
    logic        w_jmp, w_wreg, w_wmem, w_asel, w_ctr2;
    logic [2:0]  w_wb;
    logic [31:0] w_imm, w_res;

    always_ff @(posedge clk) begin
        if (!rstn) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    assign w_opc = instruct[6:0];
    assign w_f3  = instruct[14:12];
    assign w_alt = instruct[30];

    // funct3 -> ALU op shared by register and immediate arithmetic; sub_ok is 0 for OP-IMM
    function automatic logic [5:0] f_arith(input logic [2:0] f3, input logic alt, input logic sub_ok);
        case (f3)
            3'd0:    f_arith = (alt && sub_ok) ? ALU_SUB : ALU_ADD;
            3'd1:    f_arith = ALU_SLL;
            3'd2:    f_arith = ALU_SLT;
            3'd3:    f_arith = ALU_SLTU;
            3'd4:    f_arith = ALU_XOR;
            3'd5:    f_arith = alt ? ALU_SRA : ALU_SRL;
            3'd6:    f_arith = ALU_OR;
            default: f_arith = ALU_AND;
        endcase
    endfunction

    always_comb begin
        w_exop = 3'd0;
        w_alu  = ALU_ADD;
        w_br   = 2'b00;
        w_jmp  = 1'b0;
        w_wreg = 1'b0;
        w_wmem = 1'b0;
        w_asel = 1'b0;
        w_ctr2 = 1'b0;
        w_bsel = 2'b00;
        w_m2   = 2'b00;
        w_wb   = 3'd0;
        case (w_opc)
            OP_R: begin
                w_alu  = f_arith(w_f3, w_alt, 1'b1);
                w_wreg = 1'b1;
            end
            OP_I: begin
                w_alu  = f_arith(w_f3, w_alt, 1'b0);
                w_exop = (w_f3 == 3'd1 || w_f3 == 3'd5) ? 3'd5 : 3'd0;
                w_bsel = 2'b01;
                w_wreg = 1'b1;
            end
            OP_LUI: begin
                w_exop = 3'd3; w_bsel = 2'b01; w_alu = ALU_PASSB; w_wreg = 1'b1;
            end
            OP_AUIPC: begin
                w_exop = 3'd3; w_asel = 1'b1; w_bsel = 2'b01; w_wreg = 1'b1;
            end
            OP_JAL: begin
                w_exop = 3'd4; w_jmp = 1'b1; w_asel = 1'b1; w_bsel = 2'b10; w_wreg = 1'b1;
            end
            OP_JALR: begin
                if (w_f3 == 3'd0) begin
                    w_jmp = 1'b1; w_asel = 1'b1; w_ctr2 = 1'b1; w_bsel = 2'b10; w_wreg = 1'b1;
                end
            end
            OP_BR: begin
                case (w_f3)
                    3'd0: begin w_alu = ALU_SUB;  w_br = 2'b01; end
                    3'd1: begin w_alu = ALU_SUB;  w_br = 2'b10; end
                    3'd4: begin w_alu = ALU_SLT;  w_br = 2'b10; end
                    3'd5: begin w_alu = ALU_SLT;  w_br = 2'b01; end
                    3'd6: begin w_alu = ALU_SLTU; w_br = 2'b10; end
                    3'd7: begin w_alu = ALU_SLTU; w_br = 2'b01; end
                    default: ;
                endcase
                if (w_br != 2'b00) w_exop = 3'd2;
            end
            OP_LD: begin
                case (w_f3)
                    3'd0: w_wb = 3'd4;
                    3'd1: w_wb = 3'd2;
                    3'd2: w_wb = 3'd1;
                    3'd4: w_wb = 3'd5;
                    3'd5: w_wb = 3'd3;
                    default: ;
                endcase
                if (w_wb != 3'd0) begin
                    w_bsel = 2'b01; w_wreg = 1'b1;
                end
            end
            OP_ST: begin
                if (w_f3 <= 3'd2) begin
                    w_exop = 3'd1; w_bsel = 2'b01; w_wmem = 1'b1;
                    w_m2   = (w_f3 == 3'd0) ? 2'b10 : (w_f3 == 3'd1) ? 2'b01 : 2'b00;
                end
            end
            default: ;
        endcase
        if (instruct[11:7] == 5'd0) w_wreg = 1'b0;
    end

    always_comb begin
        w_imm = '0;
        case (w_exop)
            3'd0: w_imm = {{20{instruct[31]}}, instruct[31:20]};
            3'd1: w_imm = {{20{instruct[31]}}, instruct[31:25], instruct[11:7]};
            3'd2: w_imm = {{20{instruct[31]}}, instruct[7], instruct[30:25], instruct[11:8], 1'b0};
            3'd3: w_imm = {instruct[31:12], 12'b0};
            3'd4: w_imm = {{12{instruct[31]}}, instruct[19:12], instruct[20], instruct[30:21], 1'b0};
            3'd5: w_imm = {27'b0, instruct[24:20]};
            default: w_imm = '0;
        endcase
    end

    assign Wadd           = r_run ? instruct[11:7]  : 5'd0;
    assign Radd1          = r_run ? instruct[19:15] : 5'd0;
    assign Radd2          = r_run ? instruct[24:20] : 5'd0;
    assign imm            = r_run ? w_imm  : 32'd0;
    assign exop           = r_run ? w_exop : 3'd0;
    assign alu_ctr_o      = r_run ? w_alu  : 6'd0;
    assign branch_o       = r_run ? w_br   : 2'b00;
    assign jump_o         = r_run & w_jmp;
    assign isWreg         = r_run & w_wreg;
    assign isWmem         = r_run & w_wmem;
    assign mrs1andpc_ctr  = r_run & w_asel;
    assign mrs1andpc_ctr2 = r_run & w_ctr2;
    assign mrs2andie_ctr  = r_run ? w_bsel : 2'b00;
    assign mrs2_ctr       = r_run ? w_m2   : 2'b00;
    assign maluandmem_ctr = r_run ? w_wb   : 3'd0;

    always_comb begin
        w_res = '0;
        case (alu_ctr_o)
            ALU_ADD:   w_res = alu_rs1 + alu_rs2;
            ALU_SUB:   w_res = alu_rs1 - alu_rs2;
            ALU_SLL:   w_res = alu_rs1 << alu_rs2[4:0];
            ALU_SLT:   w_res = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
            ALU_SLTU:  w_res = {31'b0, alu_rs1 < alu_rs2};
            ALU_XOR:   w_res = alu_rs1 ^ alu_rs2;
            ALU_SRL:   w_res = alu_rs1 >> alu_rs2[4:0];
            ALU_SRA:   w_res = $signed(alu_rs1) >>> alu_rs2[4:0];
            ALU_OR:    w_res = alu_rs1 | alu_rs2;
            ALU_AND:   w_res = alu_rs1 & alu_rs2;
            ALU_PASSB: w_res = alu_rs2;
            default:   w_res = '0;
        endcase
    end

    assign res  = w_res;
    assign zero = (w_res == 32'd0);
endmodule

// File: tb/tb_decode_execute_core.sv
// Directed test-plan steps plus random instructions checked against a mnemonic-level model.
module tb_decode_execute_core;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] instruct, alu_rs1, alu_rs2;
    logic [4:0]  Wadd, Radd1, Radd2;
    logic [31:0] imm, res;
    logic [2:0]  exop, maluandmem_ctr;
    logic [5:0]  alu_ctr_o;
    logic [1:0]  branch_o, mrs2andie_ctr, mrs2_ctr;
    logic        jump_o, isWreg, isWmem, mrs1andpc_ctr, mrs1andpc_ctr2, zero;

    int n_vec = 0;
    int n_err = 0;
    bit run_m = 1'b0;

    typedef struct packed {
        logic [4:0]  wadd, r1, r2;
        logic [31:0] imm;
        logic [2:0]  exop;
        logic [5:0]  alu;
        logic [1:0]  br;
        logic        jmp, wreg, wmem, asel, ctr2;
        logic [1:0]  bsel, m2;
        logic [2:0]  wb;
    } ctl_t;

    decode_execute_core dut (
        .clk(clk), .rstn(rstn), .instruct(instruct), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .Wadd(Wadd), .Radd1(Radd1), .Radd2(Radd2), .imm(imm), .exop(exop),
        .alu_ctr_o(alu_ctr_o), .branch_o(branch_o), .jump_o(jump_o), .isWreg(isWreg),
        .isWmem(isWmem), .mrs1andpc_ctr(mrs1andpc_ctr), .mrs1andpc_ctr2(mrs1andpc_ctr2),
        .mrs2andie_ctr(mrs2andie_ctr), .mrs2_ctr(mrs2_ctr), .maluandmem_ctr(maluandmem_ctr),
        .res(res), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) run_m <= rstn;

    function automatic logic [31:0] imm_of(input logic [31:0] ins, input logic [2:0] fmt);
        logic [31:0] s;
        s = ins;
        case (fmt)
            3'd0: return 32'($signed(s) >>> 20);
            3'd1: return (32'($signed(s) >>> 25) << 5) | 32'(ins[11:7]);
            3'd2: return (32'($signed(s) >>> 31) << 12) | (32'(ins[7]) << 11)
                         | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            3'd3: return s & 32'hFFFF_F000;
            3'd4: return (32'($signed(s) >>> 31) << 20) | (32'(ins[19:12]) << 12)
                         | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            3'd5: return 32'(ins[24:20]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic ctl_t model(input logic [31:0] ins, input bit run);
        ctl_t e;
        logic [5:0] arith [8];
        logic [2:0] f3;
        e = '0;
        arith = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd9};
        f3 = ins[14:12];
        if (!run) return e;
        e.wadd = ins[11:7]; e.r1 = ins[19:15]; e.r2 = ins[24:20];
        case (ins[6:0])
            7'h33: begin
                e.alu = arith[f3];
                if (ins[30] && f3 == 3'd0) e.alu = 6'd1;
                if (ins[30] && f3 == 3'd5) e.alu = 6'd7;
                e.wreg = 1;
            end
            7'h13: begin
                e.alu = arith[f3];
                if (ins[30] && f3 == 3'd5) e.alu = 6'd7;
                if (f3 == 3'd1 || f3 == 3'd5) e.exop = 3'd5;
                e.bsel = 2'b01; e.wreg = 1;
            end
            7'h37: begin e.exop = 3; e.bsel = 1; e.alu = 10; e.wreg = 1; end
            7'h17: begin e.exop = 3; e.asel = 1; e.bsel = 1; e.wreg = 1; end
            7'h6F: begin e.exop = 4; e.jmp = 1; e.asel = 1; e.bsel = 2; e.wreg = 1; end
            7'h67: if (f3 == 0) begin e.jmp = 1; e.asel = 1; e.ctr2 = 1; e.bsel = 2; e.wreg = 1; end
            7'h63: begin
                case (f3)
                    0: begin e.alu = 1; e.br = 1; end   // BEQ
                    1: begin e.alu = 1; e.br = 2; end   // BNE
                    4: begin e.alu = 3; e.br = 2; end   // BLT
                    5: begin e.alu = 3; e.br = 1; end   // BGE
                    6: begin e.alu = 4; e.br = 2; end   // BLTU
                    7: begin e.alu = 4; e.br = 1; end   // BGEU
                    default: ;
                endcase
                if (e.br != 0) e.exop = 2;
            end
            7'h03: begin
                case (f3)
                    0: e.wb = 4; 1: e.wb = 2; 2: e.wb = 1; 4: e.wb = 5; 5: e.wb = 3;
                    default: ;
                endcase
                if (e.wb != 0) begin e.bsel = 1; e.wreg = 1; end
            end
            7'h23: begin
                if (f3 <= 2) begin
                    e.exop = 1; e.bsel = 1; e.wmem = 1;
                    e.m2 = (f3 == 0) ? 2'b10 : (f3 == 1) ? 2'b01 : 2'b00;
                end
            end
            default: ;
        endcase
        if (ins[11:7] == 0) e.wreg = 0;
        e.imm = imm_of(ins, e.exop);
        return e;
    endfunction

    function automatic logic [31:0] alu_of(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            0: return a + b;
            1: return a - b;
            2: return a << sh;
            3: return ($signed(a) < $signed(b)) ? 1 : 0;
            4: return (a < b) ? 1 : 0;
            5: return a ^ b;
            6: return a >> sh;
            7: return 32'($signed(a) >>> sh);
            8: return a | b;
            9: return a & b;
            10: return b;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (instr %h)", tag, obs, exp, instruct);
        end
    endtask

    task automatic check_all();
        ctl_t e;
        logic [31:0] er;
        e  = model(instruct, run_m);
        er = alu_of(e.alu, alu_rs1, alu_rs2);
        chk("Wadd", 32'(Wadd), 32'(e.wadd));
        chk("Radd1", 32'(Radd1), 32'(e.r1));
        chk("Radd2", 32'(Radd2), 32'(e.r2));
        chk("imm", imm, e.imm);
        chk("exop", 32'(exop), 32'(e.exop));
        chk("alu_ctr_o", 32'(alu_ctr_o), 32'(e.alu));
        chk("branch_o", 32'(branch_o), 32'(e.br));
        chk("jump_o", 32'(jump_o), 32'(e.jmp));
        chk("isWreg", 32'(isWreg), 32'(e.wreg));
        chk("isWmem", 32'(isWmem), 32'(e.wmem));
        chk("mrs1andpc_ctr", 32'(mrs1andpc_ctr), 32'(e.asel));
        chk("mrs1andpc_ctr2", 32'(mrs1andpc_ctr2), 32'(e.ctr2));
        chk("mrs2andie_ctr", 32'(mrs2andie_ctr), 32'(e.bsel));
        chk("mrs2_ctr", 32'(mrs2_ctr), 32'(e.m2));
        chk("maluandmem_ctr", 32'(maluandmem_ctr), 32'(e.wb));
        chk("res", res, er);
        chk("zero", 32'(zero), 32'(er == 0));
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        instruct = ins; alu_rs1 = a; alu_rs2 = b;
        #1 check_all();
    endtask

    initial begin
        logic [6:0] opcs [9];
        logic [31:0] ins, a, b;
        int k;
        opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
        rstn = 1'b0; instruct = 32'h0050_0093; alu_rs1 = 32'd7; alu_rs2 = 32'd9;
        repeat (2) @(posedge clk);
        #1 check_all();
        chk("rst_isWreg", 32'(isWreg), 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_res_add", res, 32'd16);

        rstn = 1'b1;
        @(posedge clk);
        #1 check_all();
        chk("addi_isWreg", 32'(isWreg), 32'd1);
        chk("addi_Wadd", 32'(Wadd), 32'd1);
        chk("addi_imm", imm, 32'd5);
        chk("addi_bsel", 32'(mrs2andie_ctr), 32'd1);

        step(32'h4020_8133, 32'd3, 32'd5);
        chk("sub_alu", 32'(alu_ctr_o), 32'd1);
        chk("sub_res", res, 32'hFFFF_FFFE);
        step(32'hFE20_CEE3, 32'hFFFF_FFFF, 32'd1);
        chk("blt_res", res, 32'd1);
        chk("blt_br", 32'(branch_o), 32'd2);
        chk("blt_imm", imm, 32'hFFFF_FFFC);
        step(32'hFE20_AC23, 32'd100, 32'hFFFF_FFF8);
        chk("sw_wmem", 32'(isWmem), 32'd1);
        chk("sw_imm", imm, 32'hFFFF_FFF8);
        step(32'h0010_C183, 32'd8, 32'd1);
        chk("lbu_wb", 32'(maluandmem_ctr), 32'd5);
        step(32'h00C2_80E7, 32'h0000_1000, 32'd4);
        chk("jalr_ctr2", 32'(mrs1andpc_ctr2), 32'd1);
        chk("jalr_res", res, 32'h0000_1004);
        step(32'h1234_52B7, 32'd0, 32'h1234_5000);
        chk("lui_imm", imm, 32'h1234_5000);
        step(32'h4040_5113, 32'h8000_0000, 32'd4);
        chk("srai_res", res, 32'hF800_0000);
        step(32'h0000_007F, 32'd1, 32'd2);
        chk("nop_alu", 32'(alu_ctr_o), 32'd0);
        step(32'h0010_0013, 32'd0, 32'd1);
        chk("x0_isWreg", 32'(isWreg), 32'd0);

        // reset mid-operation only takes effect at the next edge
        @(negedge clk);
        instruct = 32'h0020_81B3; alu_rs1 = 32'd1; alu_rs2 = 32'd2; rstn = 1'b0;
        #1 check_all();
        chk("midrst_before", 32'(isWreg), 32'd1);
        @(negedge clk);
        #1 check_all();
        chk("midrst_after", 32'(isWreg), 32'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1 check_all();

        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            k = $urandom_range(0, 9);
            if (k < 9) ins[6:0] = opcs[k];
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 31));
            step(ins, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
